// File: rtl/npc_pkg.sv
// npc_pkg: shared types and constants for the NPC sequencer.
// Holds the FSM state encoding, reset PC default, NOP encoding and ecall cause.
// Imported by the controller, its next-PC mux and its bus interface.
package npc_pkg;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_HALT  = 3'd5
  } state_e;

  localparam logic [31:0] RST_PC_DEF     = 32'h8000_0000;
  localparam logic [31:0] NOP_INST       = 32'h0000_0013;
  // mcause value the CSR file records when trap_wen fires.
  localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;

endpackage

// File: rtl/npc_ctrl_if.sv
// npc_ctrl_if: fetch and load/store request/valid handshakes of the NPC core.
// master = sequencer side (drives requests), slave = IFU/LSU bus side.
// Requests are held until the matching valid; errors are qualified by valid.
interface npc_ctrl_if #(
  parameter int DATA_LEN = 32
);
  logic                ifu_req;
  logic [DATA_LEN-1:0] ifu_addr;
  logic                ifu_valid;
  logic                ifu_err;
  logic [31:0]         ifu_rdata;
  logic                lsu_req;
  logic                lsu_valid;
  logic                lsu_err;

  modport master (
    output ifu_req, ifu_addr, lsu_req,
    input  ifu_valid, ifu_err, ifu_rdata, lsu_valid, lsu_err
  );

  modport slave (
    input  ifu_req, ifu_addr, lsu_req,
    output ifu_valid, ifu_err, ifu_rdata, lsu_valid, lsu_err
  );
endinterface

// File: rtl/npc_next_pc.sv
// npc_next_pc: combinational next-PC priority mux (ecall, mret, jump, branch, pc+4).
// Latency: zero cycles, purely combinational.
// Backpressure: none; the sequencer only samples the result in WB.
module npc_next_pc #(
  parameter int DATA_LEN = 32
) (
  input  logic [DATA_LEN-1:0] pc_s_i,
  input  logic                ecall_i,
  input  logic                mret_i,
  input  logic                jump_without_i,
  input  logic                inst_jump_flag_i,
  input  logic                br_taken_i,
  input  logic [DATA_LEN-1:0] jump_target_i,
  input  logic [DATA_LEN-1:0] mtvec_i,
  input  logic [DATA_LEN-1:0] mepc_i,
  output logic [DATA_LEN-1:0] npc_o
);

  logic [DATA_LEN-1:0] sel;

  // Priority select; traps beat returns beat jumps beat branches beat fall-through.
  always_comb begin
    sel = pc_s_i;
    if (ecall_i)                               sel = mtvec_i;
    else if (mret_i)                           sel = mepc_i;
    else if (jump_without_i)                   sel = jump_target_i;
    else if (inst_jump_flag_i && br_taken_i)   sel = jump_target_i;
  end

  // Fetches are always word-aligned.
  assign npc_o = {sel[DATA_LEN-1:2], 2'b00};

endmodule

// File: rtl/npc_ctrl.sv
// npc_ctrl: multi-cycle RESET/FETCH/EXEC/MEM/WB/HALT sequencer owning pc and inst.
// Latency: 3 cycles per non-memory instruction, 4+ for load/store (LSU wait extends MEM).
// Backpressure: FETCH/MEM hold their request until valid; optional counters under NPC_CTRL_PERF_EN.
module npc_ctrl
  import npc_pkg::*;
#(
  parameter int                  DATA_LEN = 32,
  parameter logic [DATA_LEN-1:0] RST_PC   = RST_PC_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  npc_ctrl_if.master          bus,
  output logic [31:0]         inst,
  output logic [DATA_LEN-1:0] pc,
  output logic [DATA_LEN-1:0] pc_s,
  input  logic                is_load,
  input  logic                is_store,
  input  logic                jump_without,
  input  logic                inst_jump_flag,
  input  logic                br_taken,
  input  logic [DATA_LEN-1:0] jump_target,
  input  logic                ecall,
  input  logic                mret,
  input  logic                ebreak,
  input  logic [DATA_LEN-1:0] mtvec,
  input  logic [DATA_LEN-1:0] mepc,
  input  logic                dest_wen,
  input  logic                csr_wen_in,
  output logic                rf_wen,
  output logic                csr_wen,
  output logic                trap_wen,
  output logic                unusual_flag,
  output logic                halted,
  output logic [63:0]         cycle_cnt,
  output logic [63:0]         instret_cnt
);

  state_e              state_q, state_d;
  logic [DATA_LEN-1:0] pc_q, pc_d;
  logic [31:0]         inst_q, inst_d;
  logic                unusual_q, unusual_d;
  logic [DATA_LEN-1:0] npc;
  logic                ifu_req_w, lsu_req_w;

  assign pc_s = pc_q + DATA_LEN'(4);

  npc_next_pc #(.DATA_LEN(DATA_LEN)) u_next_pc (
    .pc_s_i           (pc_s),
    .ecall_i          (ecall),
    .mret_i           (mret),
    .jump_without_i   (jump_without),
    .inst_jump_flag_i (inst_jump_flag),
    .br_taken_i       (br_taken),
    .jump_target_i    (jump_target),
    .mtvec_i          (mtvec),
    .mepc_i           (mepc),
    .npc_o            (npc)
  );

  // State, pc, instruction register and fault latch; reset aborts any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RESET;
      pc_q      <= RST_PC;
      inst_q    <= NOP_INST;
      unusual_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      unusual_q <= unusual_d;
    end
  end

  // Next-state, register updates and per-state strobes.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    unusual_d = unusual_q;
    ifu_req_w = 1'b0;
    lsu_req_w = 1'b0;
    rf_wen    = 1'b0;
    csr_wen   = 1'b0;
    trap_wen  = 1'b0;
    unique case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: begin
        ifu_req_w = 1'b1;
        if (bus.ifu_valid) begin
          inst_d    = bus.ifu_rdata;
          unusual_d = bus.ifu_err;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // A faulted fetch skips memory so no bus access is made on garbage.
        if (unusual_q)                state_d = ST_WB;
        else if (is_load || is_store) state_d = ST_MEM;
        else                          state_d = ST_WB;
      end
      ST_MEM: begin
        lsu_req_w = 1'b1;
        if (bus.lsu_valid) begin
          unusual_d = bus.lsu_err;
          state_d   = ST_WB;
        end
      end
      ST_WB: begin
        rf_wen   = dest_wen   & ~unusual_q;
        csr_wen  = csr_wen_in & ~unusual_q;
        trap_wen = ecall      & ~unusual_q;
        if (unusual_q || ebreak) begin
          state_d = ST_HALT;
        end else begin
          pc_d    = npc;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  assign bus.ifu_req  = ifu_req_w;
  assign bus.ifu_addr = pc_q;
  assign bus.lsu_req  = lsu_req_w;
  assign inst         = inst_q;
  assign pc           = pc_q;
  assign unusual_flag = unusual_q;
  assign halted       = (state_q == ST_HALT);

`ifdef NPC_CTRL_PERF_EN
  logic [63:0] cycle_q, cycle_d;
  logic [63:0] instret_q, instret_d;

  // Count active cycles and cleanly retired instructions; both wrap at 2^64.
  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (state_q != ST_RESET && state_q != ST_HALT) cycle_d = cycle_q + 64'd1;
    if (state_q == ST_WB && !unusual_q)             instret_d = instret_q + 64'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= 64'd0;
      instret_q <= 64'd0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = 64'd0;
  assign instret_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_npc_ctrl.sv
// tb_npc_ctrl: directed self-checking bench for the npc_ctrl sequencer.
// Plays IFU, LSU and decoder; expected values are hand-computed constants.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_npc_ctrl;

  logic        clk;
  logic        rst_n;
  logic        is_load, is_store, jump_without, inst_jump_flag, br_taken;
  logic [31:0] jump_target, mtvec, mepc;
  logic        ecall, mret, ebreak, dest_wen, csr_wen_in;
  logic [31:0] inst, pc, pc_s;
  logic        rf_wen, csr_wen, trap_wen, unusual_flag, halted;
  logic [63:0] cycle_cnt, instret_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  npc_ctrl_if #(.DATA_LEN(32)) bus ();

  npc_ctrl #(.DATA_LEN(32), .RST_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .inst           (inst),
    .pc             (pc),
    .pc_s           (pc_s),
    .is_load        (is_load),
    .is_store       (is_store),
    .jump_without   (jump_without),
    .inst_jump_flag (inst_jump_flag),
    .br_taken       (br_taken),
    .jump_target    (jump_target),
    .ecall          (ecall),
    .mret           (mret),
    .ebreak         (ebreak),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .dest_wen       (dest_wen),
    .csr_wen_in     (csr_wen_in),
    .rf_wen         (rf_wen),
    .csr_wen        (csr_wen),
    .trap_wen       (trap_wen),
    .unusual_flag   (unusual_flag),
    .halted         (halted),
    .cycle_cnt      (cycle_cnt),
    .instret_cnt    (instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr_dec();
    is_load = 0; is_store = 0; jump_without = 0; inst_jump_flag = 0; br_taken = 0;
    jump_target = 32'h0; ecall = 0; mret = 0; ebreak = 0; dest_wen = 0; csr_wen_in = 0;
  endtask

  // Runs one non-memory instruction from a FETCH-state falling edge to the next FETCH.
  task automatic do_inst(input string tag, input logic [31:0] cur_pc, input logic [31:0] iw,
                         input logic exp_rf, input logic exp_csr, input logic exp_trap,
                         input logic [31:0] exp_next);
    chk({tag, ".req"},  64'(bus.ifu_req), 64'h1);
    chk({tag, ".addr"}, 64'(bus.ifu_addr), 64'(cur_pc));
    bus.ifu_valid = 1; bus.ifu_err = 0; bus.ifu_rdata = iw;
    tick();
    bus.ifu_valid = 0;
    chk({tag, ".inst"},    64'(inst), 64'(iw));
    chk({tag, ".exec_rf"}, 64'(rf_wen), 64'h0);
    tick();
    chk({tag, ".rf"},    64'(rf_wen), 64'(exp_rf));
    chk({tag, ".csr"},   64'(csr_wen), 64'(exp_csr));
    chk({tag, ".trap"},  64'(trap_wen), 64'(exp_trap));
    chk({tag, ".wb_pc"}, 64'(pc), 64'(cur_pc));
    tick();
    chk({tag, ".next"},  64'(bus.ifu_addr), 64'(exp_next));
    chk({tag, ".rf_off"}, 64'(rf_wen), 64'h0);
    clr_dec();
  endtask

  initial begin
    rst_n = 0;
    bus.ifu_valid = 0; bus.ifu_err = 0; bus.ifu_rdata = 32'h0;
    bus.lsu_valid = 0; bus.lsu_err = 0;
    mtvec = 32'h0; mepc = 32'h0;
    clr_dec();
    repeat (2) tick();

    // Reset state.
    chk("rst.pc",      64'(pc), 64'h8000_0000);
    chk("rst.inst",    64'(inst), 64'h13);
    chk("rst.ifu_req", 64'(bus.ifu_req), 64'h0);
    chk("rst.lsu_req", 64'(bus.lsu_req), 64'h0);
    chk("rst.halted",  64'(halted), 64'h0);
    chk("rst.unusual", 64'(unusual_flag), 64'h0);
    chk("rst.cycle",   cycle_cnt, 64'h0);
    chk("rst.instret", instret_cnt, 64'h0);

    rst_n = 1;
    tick();   // RESET -> FETCH

    // addi x1,x0,1 with ifu_valid in the first request cycle.
    dest_wen = 1;
    do_inst("addi", 32'h8000_0000, 32'h0010_0093, 1, 0, 0, 32'h8000_0004);
    chk("addi.pc_s", 64'(pc_s), 64'h8000_0008);
`ifdef NPC_CTRL_PERF_EN
    chk("addi.cycle",   cycle_cnt, 64'd3);
    chk("addi.instret", instret_cnt, 64'd1);
`endif

    // lw with a 2-cycle LSU wait; a stray ifu_valid during MEM must be ignored.
    is_load = 1; dest_wen = 1;
    bus.ifu_valid = 1; bus.ifu_rdata = 32'h0000_2103;
    tick();
    bus.ifu_valid = 0;
    chk("lw.exec_lsu", 64'(bus.lsu_req), 64'h0);
    tick();
    chk("lw.mem1", 64'(bus.lsu_req), 64'h1);
    bus.ifu_valid = 1; bus.ifu_rdata = 32'hDEAD_BEEF;
    tick();
    bus.ifu_valid = 0;
    chk("lw.mem2", 64'(bus.lsu_req), 64'h1);
    tick();
    chk("lw.mem3", 64'(bus.lsu_req), 64'h1);
    chk("lw.mem_rf", 64'(rf_wen), 64'h0);
    bus.lsu_valid = 1;
    tick();
    bus.lsu_valid = 0;
    chk("lw.wb_req",  64'(bus.lsu_req), 64'h0);
    chk("lw.wb_rf",   64'(rf_wen), 64'h1);
    chk("lw.inst",    64'(inst), 64'h0000_2103);
    tick();
    clr_dec();
    chk("lw.next", 64'(bus.ifu_addr), 64'h8000_0008);
`ifdef NPC_CTRL_PERF_EN
    chk("lw.instret", instret_cnt, 64'd2);
`endif

    // beq taken; low target bits must be cleared.
    inst_jump_flag = 1; br_taken = 1; jump_target = 32'h8000_0102;
    do_inst("beq_t", 32'h8000_0008, 32'h0000_0063, 0, 0, 0, 32'h8000_0100);
    // beq not taken.
    inst_jump_flag = 1; br_taken = 0; jump_target = 32'h8000_0200;
    do_inst("beq_n", 32'h8000_0100, 32'h0000_0063, 0, 0, 0, 32'h8000_0104);
    // ecall: trap strobe, vector to mtvec.
    ecall = 1; mtvec = 32'h8000_0200;
    do_inst("ecall", 32'h8000_0104, 32'h0000_0073, 0, 0, 1, 32'h8000_0200);
    // mret: return to mepc.
    mret = 1; mepc = 32'h8000_0008;
    do_inst("mret", 32'h8000_0200, 32'h3020_0073, 0, 0, 0, 32'h8000_0008);
    // csrrw: both write strobes.
    csr_wen_in = 1; dest_wen = 1;
    do_inst("csrrw", 32'h8000_0008, 32'h3050_90F3, 1, 1, 0, 32'h8000_000C);
    // jal to the top of the address space.
    jump_without = 1; dest_wen = 1; jump_target = 32'hFFFF_FFFC;
    do_inst("jal", 32'h8000_000C, 32'h0000_00EF, 1, 0, 0, 32'hFFFF_FFFC);
    chk("wrap.pc_s", 64'(pc_s), 64'h0);
    dest_wen = 1;
    do_inst("wrap", 32'hFFFF_FFFC, 32'h0010_0093, 1, 0, 0, 32'h0000_0000);

    // Fetch bus error: no commit, halt with pc unchanged.
    dest_wen = 1; csr_wen_in = 1;
    bus.ifu_valid = 1; bus.ifu_err = 1; bus.ifu_rdata = 32'h0010_0093;
    tick();
    bus.ifu_valid = 0; bus.ifu_err = 0;
    chk("ferr.unusual", 64'(unusual_flag), 64'h1);
    chk("ferr.lsu_req", 64'(bus.lsu_req), 64'h0);
    tick();
    chk("ferr.rf",  64'(rf_wen), 64'h0);
    chk("ferr.csr", 64'(csr_wen), 64'h0);
    tick();
    clr_dec();
    chk("ferr.halted", 64'(halted), 64'h1);
    chk("ferr.pc",     64'(pc), 64'h0);
    repeat (3) tick();
    chk("ferr.ifu_req", 64'(bus.ifu_req), 64'h0);
    chk("ferr.halt_hold", 64'(halted), 64'h1);
`ifdef NPC_CTRL_PERF_EN
    chk("ferr.cycle",   cycle_cnt, 64'd33);
    chk("ferr.instret", instret_cnt, 64'd9);
`else
    chk("noperf.cycle",   cycle_cnt, 64'd0);
    chk("noperf.instret", instret_cnt, 64'd0);
`endif

    // Asynchronous reset out of HALT.
    rst_n = 0;
    #1;
    chk("rst2.halted", 64'(halted), 64'h0);
    chk("rst2.pc",     64'(pc), 64'h8000_0000);
    chk("rst2.cycle",  cycle_cnt, 64'h0);
    tick();
    rst_n = 1;
    tick();

    // ebreak: retires without a register write, then halts for good.
    ebreak = 1;
    bus.ifu_valid = 1; bus.ifu_rdata = 32'h0010_0073;
    tick();
    bus.ifu_valid = 0;
    tick();
    chk("ebrk.rf", 64'(rf_wen), 64'h0);
    tick();
    clr_dec();
    chk("ebrk.halted", 64'(halted), 64'h1);
    chk("ebrk.pc",     64'(pc), 64'h8000_0000);
    repeat (3) tick();
    chk("ebrk.ifu_req", 64'(bus.ifu_req), 64'h0);
`ifdef NPC_CTRL_PERF_EN
    chk("ebrk.instret", instret_cnt, 64'd1);
    chk("ebrk.cycle",   cycle_cnt, 64'd3);
`endif

    // Reset in the middle of a load's MEM phase.
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
    dest_wen = 1;
    do_inst("addi2", 32'h8000_0000, 32'h0010_0093, 1, 0, 0, 32'h8000_0004);
    is_load = 1; dest_wen = 1;
    bus.ifu_valid = 1; bus.ifu_rdata = 32'h0000_2103;
    tick();
    bus.ifu_valid = 0;
    tick();
    chk("mrst.pre_req", 64'(bus.lsu_req), 64'h1);
    rst_n = 0;
    #1;
    chk("mrst.lsu_req", 64'(bus.lsu_req), 64'h0);
    chk("mrst.ifu_req", 64'(bus.ifu_req), 64'h0);
    chk("mrst.pc",      64'(pc), 64'h8000_0000);
    chk("mrst.inst",    64'(inst), 64'h13);
    clr_dec();
    tick();
    rst_n = 1;
    tick();
    dest_wen = 1;
    do_inst("recover", 32'h8000_0000, 32'h0010_0093, 1, 0, 0, 32'h8000_0004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
